// File: rtl/bounded_count_gen.sv
// Modulo-(MAX_COUNT+1) count/trigger generator with a start/stop handshake and arming window.
// Define BOUNDED_COUNT_ASSERT_EN to compile in the embedded self-checks.
module bounded_count_gen #(
   parameter int WIDTH      = 4,
   parameter int MAX_COUNT  = 9,
   parameter int ARM_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             count_en,
   output logic [WIDTH-1:0] count,
   output logic             trigger,
   output logic             wrap,
   output logic             busy
);

   localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

   localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_CYCLES - 1);
   localparam logic [ARM_W-1:0] ARM_ONE  = ARM_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      RUN,
      DRAIN
   } state_t;

   state_t           state;
   logic [ARM_W-1:0] arm_cnt;
   logic             at_max;
   logic [WIDTH-1:0] count_next;

   // Wrap is decided by comparison, so the sum never needs a carry bit.
   always_comb begin
      at_max     = (count == MAX_C);
      count_next = at_max ? '0 : count + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         trigger <= 1'b0;
         wrap    <= 1'b0;
         busy    <= 1'b0;
         arm_cnt <= '0;
      end else begin
         wrap <= 1'b0;
         case (state)
            IDLE: begin
               count <= '0;
               if (start) begin
                  state   <= ARM;
                  arm_cnt <= ARM_LOAD;
                  busy    <= 1'b1;
               end
            end
            ARM: begin
               if (stop) begin
                  state <= DRAIN;
               end else if (arm_cnt == '0) begin
                  state   <= RUN;
                  trigger <= 1'b1;
               end else begin
                  arm_cnt <= arm_cnt - ARM_ONE;
               end
            end
            RUN: begin
               // A count_en coincident with stop still lands, wrap included.
               if (count_en) begin
                  count <= count_next;
                  wrap  <= at_max;
               end
               if (stop) begin
                  state   <= DRAIN;
                  trigger <= 1'b0;
               end
            end
            DRAIN: begin
               state <= IDLE;
               count <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               count   <= '0;
               trigger <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef BOUNDED_COUNT_ASSERT_EN
   always @(posedge clk) begin
      if (trigger) begin
         assert (count <= MAX_C)
         else $error("count %0d above MAX_COUNT while triggered", count);
      end
   end

   wrap_zero_p : assert property (
      @(posedge clk) disable iff (reset) wrap |-> count == '0
   );

   trig_from_arm_p : assert property (
      @(posedge clk) $rose(trigger) |-> $past(state) == ARM
   );

   reset_clear_p : assert property (
      @(posedge clk) reset |=> (count == '0 && !trigger && !busy)
   );
`endif

endmodule
